// File: rtl/moving_average_param_if.sv
// Sample/result bundle of the parameterised moving-average filter.
// master drives samples and control, slave is the filter.
interface moving_average_param_if #(
   parameter int unsigned DATA_W = 16
);
   logic                     enable;
   logic                     clear;
   logic                     data_refresh;
   logic signed [DATA_W-1:0] din;
   logic [2:0]               mode;
   logic                     output_refresh_mode;
   logic signed [DATA_W-1:0] dout;
   logic                     output_pulse;
   logic                     fill_done;

   modport master (
      output enable, clear, data_refresh, din, mode, output_refresh_mode,
      input  dout, output_pulse, fill_done
   );

   modport slave (
      input  enable, clear, data_refresh, din, mode, output_refresh_mode,
      output dout, output_pulse, fill_done
   );
endinterface

// File: rtl/moving_average_param.sv
// Power-of-two window moving average over a circular sample buffer.
// Define MAVG_ROUND_EN to round half up instead of flooring the average.
module moving_average_param #(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned LOG2_MAX = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   moving_average_param_if.slave bus
);
   localparam int unsigned DEPTH = 1 << LOG2_MAX;
   localparam int unsigned SUM_W = DATA_W + LOG2_MAX;
   localparam int unsigned CNT_W = LOG2_MAX + 1;

   localparam logic [0:0] S_FILL = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]               state_q, state_d;
   logic signed [SUM_W-1:0]  sum_q, sum_d;
   logic [CNT_W-1:0]         fill_q, fill_d;
   logic [CNT_W-1:0]         dec_q, dec_d;
   logic [LOG2_MAX-1:0]      wptr_q;
   logic [2:0]               mode_q, mode_d;
   logic signed [DATA_W-1:0] dout_q, dout_d;
   logic                     pulse_q, pulse_d;
   logic                     done_q, done_d;
   logic signed [DATA_W-1:0] mem_q [DEPTH];

   logic [2:0]               mode_clamp_c;
   logic                     restart_c;
   logic                     wr_en_c;
   logic [CNT_W-1:0]         win_n_c;
   logic [LOG2_MAX-1:0]      oldest_idx_c;
   logic signed [SUM_W-1:0]  din_ext_c;
   logic signed [SUM_W-1:0]  oldest_ext_c;

   // Divide the running sum by the window size with an arithmetic shift.
   function automatic logic signed [DATA_W-1:0] scale(
      input logic signed [SUM_W-1:0] s,
      input logic [2:0]              sh
   );
      logic signed [SUM_W:0] t;
      t = (SUM_W+1)'(s);
`ifdef MAVG_ROUND_EN
      if (sh != 3'd0) begin
         logic signed [SUM_W:0] half;
         half = (SUM_W+1)'(1) << (sh - 3'd1);
         t    = t + half;
      end
`endif
      t = t >>> sh;
      return t[DATA_W-1:0];
   endfunction

   assign mode_clamp_c = (bus.mode > 3'(LOG2_MAX)) ? 3'(LOG2_MAX) : bus.mode;
   assign restart_c    = bus.clear || (mode_q != mode_clamp_c);
   assign win_n_c      = CNT_W'(1) << mode_q;
   // Oldest sample of the window still sits N slots behind the write pointer.
   assign oldest_idx_c = wptr_q - win_n_c[LOG2_MAX-1:0];
   assign din_ext_c    = SUM_W'(bus.din);
   assign oldest_ext_c = SUM_W'(mem_q[oldest_idx_c]);

   // Next-state and output decode.
   always_comb begin
      state_d = state_q;
      sum_d   = sum_q;
      fill_d  = fill_q;
      dec_d   = dec_q;
      mode_d  = mode_q;
      dout_d  = dout_q;
      pulse_d = 1'b0;
      done_d  = done_q;
      wr_en_c = 1'b0;

      if (bus.enable) begin
         wr_en_c = bus.data_refresh;
         if (restart_c) begin
            mode_d  = mode_clamp_c;
            state_d = S_FILL;
            sum_d   = '0;
            fill_d  = '0;
            dec_d   = '0;
            done_d  = 1'b0;
            if (bus.data_refresh) begin
               // Coincident sample opens the new fill without a pulse.
               sum_d  = din_ext_c;
               fill_d = CNT_W'(1);
               if (mode_clamp_c == 3'd0) begin
                  state_d = S_RUN;
                  done_d  = 1'b1;
               end
            end
         end else if (bus.data_refresh) begin
            case (state_q)
               S_FILL: begin
                  sum_d  = sum_q + din_ext_c;
                  fill_d = fill_q + CNT_W'(1);
                  if (fill_d == win_n_c) begin
                     state_d = S_RUN;
                     done_d  = 1'b1;
                     dec_d   = '0;
                     pulse_d = 1'b1;
                     dout_d  = scale(sum_d, mode_q);
                  end
               end
               default: begin
                  sum_d   = sum_q + din_ext_c - oldest_ext_c;
                  dec_d   = ((dec_q + CNT_W'(1)) == win_n_c) ? '0 : dec_q + CNT_W'(1);
                  pulse_d = bus.output_refresh_mode || (dec_d == '0);
                  if (pulse_d) dout_d = scale(sum_d, mode_q);
               end
            endcase
         end
      end
   end

   // State, accumulator and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FILL;
         sum_q   <= '0;
         fill_q  <= '0;
         dec_q   <= '0;
         mode_q  <= '0;
         wptr_q  <= '0;
         dout_q  <= '0;
         pulse_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sum_q   <= sum_d;
         fill_q  <= fill_d;
         dec_q   <= dec_d;
         mode_q  <= mode_d;
         dout_q  <= dout_d;
         pulse_q <= pulse_d;
         done_q  <= done_d;
         if (wr_en_c) wptr_q <= wptr_q + LOG2_MAX'(1);
      end
   end

   // Sample history; survives restarts, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= '{default: '0};
      end else if (wr_en_c) begin
         mem_q[wptr_q] <= bus.din;
      end
   end

   assign bus.dout         = dout_q;
   assign bus.output_pulse = pulse_q;
   assign bus.fill_done    = done_q;
endmodule

// File: tb/tb_moving_average_param.sv
// Directed plus randomized bench for moving_average_param against a
// sample-history reference model (window average by integer division).
module tb_moving_average_param;
   localparam int unsigned DW = 16;
   localparam int unsigned LM = 4;

   logic clk;
   logic rst_n;

   moving_average_param_if #(.DATA_W(DW)) bus ();

   moving_average_param #(.DATA_W(DW), .LOG2_MAX(LM)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model: samples accepted since the last restart.
   longint hist[$];
   int     k_cnt;
   int     mq;
   bit     m_pulse;
   bit     m_fill;
   longint m_dout;

   int cur_mode;
   bit cur_rm;

   function automatic longint floor_div(input longint a, input longint b);
      longint q;
      q = a / b;
      if ((a % b) != 0 && a < 0) q = q - 1;
      return q;
   endfunction

   function automatic longint ref_avg(input int n);
      longint s;
      s = 0;
      for (int i = 0; i < n; i++) s += hist[hist.size() - 1 - i];
`ifdef MAVG_ROUND_EN
      if (n > 1) return floor_div(s + n / 2, n);
`endif
      return floor_div(s, n);
   endfunction

   function automatic void model_reset();
      hist.delete();
      k_cnt   = 0;
      mq      = 0;
      m_pulse = 1'b0;
      m_fill  = 1'b0;
      m_dout  = 0;
   endfunction

   function automatic void model_step(input bit en, input bit clr, input bit dr,
                                      input int d, input int md, input bit rm);
      int mc;
      int n;
      bit restarted;
      m_pulse   = 1'b0;
      restarted = 1'b0;
      if (!en) return;
      mc = (md > int'(LM)) ? int'(LM) : md;
      if (clr || mc != mq) begin
         mq = mc;
         hist.delete();
         k_cnt     = 0;
         restarted = 1'b1;
      end
      n = 1 << mq;
      if (dr) begin
         hist.push_back(longint'(d));
         if (hist.size() > 64) void'(hist.pop_front());
         k_cnt++;
         if (!restarted) begin
            if (k_cnt == n) m_pulse = 1'b1;
            else if (k_cnt > n && (rm || ((k_cnt - n) % n) == 0)) m_pulse = 1'b1;
         end
         if (m_pulse) m_dout = ref_avg(n);
      end
      m_fill = (k_cnt >= n);
   endfunction

   task automatic chk(input string tag, input logic signed [63:0] got,
                      input logic signed [63:0] exp);
      tests++;
      assert (got === exp)
      else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Apply one cycle of inputs, advance the model, compare after the edge.
   task automatic cyc(input bit en, input bit clr, input bit dr, input int d,
                      input int md, input bit rm);
      bus.enable              = en;
      bus.clear               = clr;
      bus.data_refresh        = dr;
      bus.din                 = DW'(d);
      bus.mode                = 3'(md);
      bus.output_refresh_mode = rm;
      model_step(en, clr, dr, d, md, rm);
      @(posedge clk);
      #1;
      chk("pulse", 64'(bus.output_pulse), 64'(m_pulse));
      chk("dout", 64'(bus.dout), 64'(m_dout));
      chk("fill_done", 64'(bus.fill_done), 64'(m_fill));
   endtask

   task automatic sample(input int d);
      cyc(1'b1, 1'b0, 1'b1, d, cur_mode, cur_rm);
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_dout", 64'(bus.dout), 64'sd0);
      chk("rst_pulse", 64'(bus.output_pulse), 64'sd0);
      chk("rst_fill", 64'(bus.fill_done), 64'sd0);
      model_reset();
      @(posedge clk);
      #3 rst_n = 1'b1;
   endtask

   initial begin
      int exp_run[4];
      logic signed [DW-1:0] rs;
      int d;
      bit en, clr, dr;

      exp_run = '{14, 18, 22, 26};
      rst_n = 1'b1;
      bus.enable = 1'b0;
      bus.clear = 1'b0;
      bus.data_refresh = 1'b0;
      bus.din = '0;
      bus.mode = '0;
      bus.output_refresh_mode = 1'b0;
      model_reset();
      do_reset();

      // Decimated window of 4.
      cur_mode = 2;
      cur_rm   = 1'b0;
      sample(4); sample(8); sample(12); sample(16);
      chk("first_avg", 64'(bus.dout), 64'sd10);
      chk("first_pulse", 64'(bus.output_pulse), 64'sd1);
      chk("first_fill", 64'(bus.fill_done), 64'sd1);
      sample(20); sample(24); sample(28); sample(32);
      chk("decim_avg", 64'(bus.dout), 64'sd26);
      chk("decim_pulse", 64'(bus.output_pulse), 64'sd1);

      // Same stream with per-sample output.
      do_reset();
      cur_rm = 1'b1;
      sample(4); sample(8); sample(12); sample(16);
      chk("rm1_first", 64'(bus.dout), 64'sd10);
      for (int i = 0; i < 4; i++) begin
         sample(20 + 4 * i);
         chk("rm1_run", 64'(bus.dout), 64'(exp_run[i]));
         chk("rm1_pulse", 64'(bus.output_pulse), 64'sd1);
      end

      // Negative rounding direction.
      cur_mode = 1;
      cur_rm   = 1'b0;
      sample(-3); sample(-4);
`ifdef MAVG_ROUND_EN
      chk("neg_round", 64'(bus.dout), -64'sd3);
`else
      chk("neg_floor", 64'(bus.dout), -64'sd4);
`endif

      // Full-scale extremes in the largest window.
      cur_mode = 4;
      for (int i = 0; i < 16; i++) sample(32767);
      chk("max_pos", 64'(bus.dout), 64'sd32767);
      for (int i = 0; i < 16; i++) sample(-32768);
      chk("max_neg", 64'(bus.dout), -64'sd32768);
      chk("max_neg_pulse", 64'(bus.output_pulse), 64'sd1);

      // Mode change in RUN restarts with the coincident sample.
      cur_mode = 3;
      for (int i = 1; i <= 8; i++) sample(i * 10);
      chk("m3_fill", 64'(bus.fill_done), 64'sd1);
      cur_mode = 1;
      sample(100);
      chk("mchg_fill", 64'(bus.fill_done), 64'sd0);
      chk("mchg_pulse", 64'(bus.output_pulse), 64'sd0);
      sample(50);
      chk("mchg_avg", 64'(bus.dout), 64'sd75);
      chk("mchg_pulse2", 64'(bus.output_pulse), 64'sd1);

      // Enable low freezes everything; clear restarts the fill.
      sample(7);
      for (int i = 0; i < 5; i++) begin
         rs = DW'($urandom);
         cyc(1'b0, 1'b0, 1'b1, int'(rs), cur_mode, cur_rm);
         chk("frz_pulse", 64'(bus.output_pulse), 64'sd0);
         chk("frz_fill", 64'(bus.fill_done), 64'sd1);
      end
      sample(9);
      cyc(1'b1, 1'b1, 1'b0, 0, cur_mode, cur_rm);
      chk("clr_fill", 64'(bus.fill_done), 64'sd0);
      sample(1); sample(2);

      // Randomized traffic including clears, mode changes and resets.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 99) < 1) cur_mode = int'($urandom_range(0, 7));
         if ($urandom_range(0, 99) < 5) cur_rm = ~cur_rm;
         if ($urandom_range(0, 999) < 3) do_reset();
         en  = ($urandom_range(0, 9) != 0);
         clr = ($urandom_range(0, 99) < 1);
         dr  = ($urandom_range(0, 2) != 0);
         case ($urandom_range(0, 9))
            0:       d = 32767;
            1:       d = -32768;
            default: begin
               rs = DW'($urandom);
               d  = int'(rs);
            end
         endcase
         cyc(en, clr, dr, d, cur_mode, cur_rm);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/moving_average_param.md
MOVING_AVERAGE_PARAM -- requirements
Module: moving_average_param

Interface
REQ-001 Parameter DATA_W, default 16; width of signed input/output samples, legal range 4..32.
REQ-002 Parameter LOG2_MAX, default 4; log2 of maximum window depth (max window 2^LOG2_MAX), legal range 1..6.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 enable  input  1  module enable; low freezes all state, inputs ignored.
REQ-006 clear  input  1  synchronous restart of averaging (see REQ-016).
REQ-007 data_refresh  input  1  single-cycle sample strobe qualifying din.
REQ-008 din  input  DATA_W  signed input sample.
REQ-009 mode  input  3  window select, window N = 2^mode; values above LOG2_MAX clamp to LOG2_MAX.
REQ-010 output_refresh_mode  input  1  0 = decimated output once per N samples, 1 = output every sample.
REQ-011 dout  output  DATA_W  signed averaged sample, registered.
REQ-012 output_pulse  output  1  single-cycle valid strobe for dout.
REQ-013 fill_done  output  1  high while the window holds N valid samples (state RUN).

Function
REQ-014 Storage: circular buffer of 2^LOG2_MAX DATA_W-bit entries, write pointer wptr (LOG2_MAX bits, wraps modulo 2^LOG2_MAX), accumulator sum of DATA_W+LOG2_MAX signed bits, fill counter and decimation counter of LOG2_MAX+1 bits each.
REQ-015 States: FILL (fewer than N samples since last restart) and RUN; enable low holds current state, counters, sum and outputs.
REQ-016 Restart (clear=1, or registered mode_q differs from clamped mode): sum<=0, fill counter<=0, decimation counter<=0, state<=FILL, mode_q<=clamped mode; buffer contents unchanged.
REQ-017 Restart coincident with data_refresh: that sample is the first sample of the new fill (sum<=din, fill counter<=1), no output_pulse.
REQ-018 Each accepted sample (enable & data_refresh) writes din to buf[wptr], then wptr increments.
REQ-019 FILL: sum<=sum+din; fill counter increments; on the Nth sample state<=RUN, fill_done<=1, and output_pulse asserts with that average in both output modes.
REQ-020 RUN: sum<=sum+din-buf[wptr-N] (index modulo 2^LOG2_MAX, read before the write of the same cycle).
REQ-021 Output value: dout<=(updated sum)>>>mode_q, arithmetic shift; mode_q=0 gives dout=din.
REQ-022 Latency: dout and output_pulse valid exactly 1 cycle after the accepting data_refresh cycle; dout holds between pulses.
REQ-023 No output_pulse during FILL except per REQ-019; dout unchanged during FILL.
REQ-024 RUN, output_refresh_mode=1: output_pulse on every accepted sample.
REQ-025 RUN, output_refresh_mode=0: decimation counter counts accepted samples modulo N; output_pulse when it wraps to 0 (every Nth sample after fill completion).
REQ-026 Sum never overflows: |sum| <= N*2^(DATA_W-1) fits DATA_W+LOG2_MAX bits; dout always within DATA_W signed range, no saturation logic.
REQ-027 output_refresh_mode is sampled per sample; changes take effect on the next accepted sample without restart.

Reset
REQ-028 rst_n low asynchronously forces: sum=0, buffer entries=0, wptr=0, counters=0, state=FILL, mode_q=0, dout=0, output_pulse=0, fill_done=0.
REQ-029 Reset asserted mid-window discards all history; first sample after release starts a new fill.

Configuration
REQ-030 Macro MAVG_ROUND_EN: when defined, dout=(sum+2^(mode_q-1))>>>mode_q for mode_q>0 (round half up), mode_q=0 unchanged; when undefined, plain arithmetic shift (floor toward minus infinity).

Verification
REQ-031 Reset then mode=2, refresh_mode=0, samples 4,8,12,16 -> single pulse after 4th, dout=10, fill_done=1.
REQ-032 Continue REQ-031 with samples 20,24,28,32 -> single pulse after 8th sample, dout=26; refresh_mode=1 same stream -> pulses after every RUN sample, values 14,18,22,26.
REQ-033 mode=1, samples -3,-4 -> dout=-4 without MAVG_ROUND_EN, dout=-3 with it.
REQ-034 mode=4 (LOG2_MAX=4), 16 samples of 32767 then 16 of -32768 -> dout 32767 then -32768, no overflow.
REQ-035 In RUN mode=3, change mode to 1 coincident with sample 100 -> fill_done drops, no pulse; next sample 50 -> pulse, dout=75.
REQ-036 enable low for 5 cycles with data_refresh pulsing -> no state change, no pulse; clear mid-window -> fill restarts, fill_done=0.
